// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX->MEM, aligns SRAM load data, drives MEM->WB and MEM->ID buses.
// Optional misaligned-access detection is compiled in with `define MEM_ALIGN_CHECK_EN.

package mem_stage_pkg;

  localparam int unsigned StallBus        = 6;
  localparam int unsigned ExToMemWd       = 76;
  localparam int unsigned LoadSramDataWd  = 5;
  localparam int unsigned StoreSramDataWd = 3;
  localparam int unsigned MemToWbWd       = 70;
  localparam int unsigned MemToIdWd       = 38;
  localparam int unsigned DataWd          = 32;
  localparam int unsigned RegAddrWd       = 5;

  typedef struct packed {
    logic [DataWd-1:0]    pc;
    logic                 data_ram_en;
    logic [3:0]           data_ram_wen;
    logic                 sel_rf_res;
    logic                 rf_we;
    logic [RegAddrWd-1:0] rf_waddr;
    logic [DataWd-1:0]    ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic lb;
    logic lh;
    logic lw;
    logic lbu;
    logic lhu;
  } load_t;

  typedef struct packed {
    logic sb;
    logic sh;
    logic sw;
  } store_t;

  typedef struct packed {
    logic [DataWd-1:0]    pc;
    logic                 rf_we;
    logic [RegAddrWd-1:0] rf_waddr;
    logic [DataWd-1:0]    rf_wdata;
  } mem_to_wb_t;

  typedef struct packed {
    logic                 rf_we;
    logic [RegAddrWd-1:0] rf_waddr;
    logic [DataWd-1:0]    rf_wdata;
  } mem_to_id_t;

endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [StallBus-1:0]        stall,
  input  logic [ExToMemWd-1:0]       ex_to_mem_bus,
  input  logic [LoadSramDataWd-1:0]  load_sram_ex_data,
  input  logic [StoreSramDataWd-1:0] store_sram_ex_data,
  input  logic [DataWd-1:0]          data_sram_rdata,
  output logic [MemToWbWd-1:0]       mem_to_wb_bus,
  output logic [MemToIdWd-1:0]       mem_to_id_bus,
  output logic                       addr_err
);

  localparam int unsigned SelfStallBit = 3;
  localparam int unsigned NextStallBit = 4;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_state_e;

  ex_to_mem_t  ex_bus_q, ex_bus_d;
  load_t       load_q, load_d;
  store_t      store_q, store_d;
  hold_state_e state_q, state_d;
  logic [DataWd-1:0] rdata_hold_q, rdata_hold_d;

  logic advance;
  logic bubble;
  logic held;
  logic hold_valid;
  logic [DataWd-1:0] rdata_eff;
  logic [1:0]        off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DataWd-1:0] load_data;
  logic [DataWd-1:0] rf_wdata;
  logic              rf_we_out;
  mem_to_wb_t        wb_bus;
  mem_to_id_t        id_bus;

  assign advance = ~stall[SelfStallBit];
  assign bubble  = stall[SelfStallBit] & ~stall[NextStallBit];
  assign held    = stall[SelfStallBit] & stall[NextStallBit];

  // Pipeline register next-state: capture, bubble, or hold
  always_comb begin
    ex_bus_d = ex_bus_q;
    load_d   = load_q;
    store_d  = store_q;
    if (advance) begin
      ex_bus_d = ex_to_mem_t'(ex_to_mem_bus);
      load_d   = load_t'(load_sram_ex_data);
      store_d  = store_t'(store_sram_ex_data);
    end else if (bubble) begin
      ex_bus_d = '0;
      load_d   = '0;
      store_d  = '0;
    end
  end

  // Read-data hold FSM: freeze SRAM data while the stage is stalled in place
  always_comb begin
    state_d      = state_q;
    rdata_hold_d = rdata_hold_q;
    case (state_q)
      LIVE: begin
        if (held) begin
          state_d      = HELD;
          rdata_hold_d = data_sram_rdata;
        end
      end
      HELD: begin
        if (!held) begin
          state_d = LIVE;
        end
      end
      default: state_d = LIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_bus_q     <= '0;
      load_q       <= '0;
      store_q      <= '0;
      state_q      <= LIVE;
      rdata_hold_q <= '0;
    end else begin
      ex_bus_q     <= ex_bus_d;
      load_q       <= load_d;
      store_q      <= store_d;
      state_q      <= state_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign hold_valid = (state_q == HELD);
  assign rdata_eff  = hold_valid ? rdata_hold_q : data_sram_rdata;

  assign off      = ex_bus_q.ex_result[1:0];
  assign byte_sel = 8'(rdata_eff >> {off, 3'b000});
  assign half_sel = off[1] ? rdata_eff[31:16] : rdata_eff[15:0];

  // Load extraction; decode guarantees at most one load qualifier
  always_comb begin
    load_data = '0;
    if (load_q.lb) begin
      load_data = {{24{byte_sel[7]}}, byte_sel};
    end else if (load_q.lbu) begin
      load_data = {24'b0, byte_sel};
    end else if (load_q.lh) begin
      load_data = {{16{half_sel[15]}}, half_sel};
    end else if (load_q.lhu) begin
      load_data = {16'b0, half_sel};
    end else if (load_q.lw) begin
      load_data = rdata_eff;
    end
  end

  assign rf_wdata = ex_bus_q.sel_rf_res ? load_data : ex_bus_q.ex_result;

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_err = ((load_q.lh | load_q.lhu | store_q.sh) & off[0]) |
                    ((load_q.lw | store_q.sw) & (off != 2'b00));
`else
  assign addr_err = 1'b0;
`endif

  // A faulting access must not commit to the register file
  assign rf_we_out = ex_bus_q.rf_we & ~addr_err;

  always_comb begin
    wb_bus          = '0;
    wb_bus.pc       = ex_bus_q.pc;
    wb_bus.rf_we    = rf_we_out;
    wb_bus.rf_waddr = ex_bus_q.rf_waddr;
    wb_bus.rf_wdata = rf_wdata;
    id_bus          = '0;
    id_bus.rf_we    = rf_we_out;
    id_bus.rf_waddr = ex_bus_q.rf_waddr;
    id_bus.rf_wdata = rf_wdata;
  end

  assign mem_to_wb_bus = MemToWbWd'(wb_bus);
  assign mem_to_id_bus = MemToIdWd'(id_bus);

  // Fields carried on the bus but not consumed by this stage
  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[2:0], ex_bus_q.data_ram_en,
                       ex_bus_q.data_ram_wen, store_q};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan scenarios plus randomized traffic vs a behavioural model.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  load_sram_ex_data;
  logic [2:0]  store_sram_ex_data;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic        addr_err;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .ex_to_mem_bus      (ex_to_mem_bus),
    .load_sram_ex_data  (load_sram_ex_data),
    .store_sram_ex_data (store_sram_ex_data),
    .data_sram_rdata    (data_sram_rdata),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .mem_to_id_bus      (mem_to_id_bus),
    .addr_err           (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0] LB  = 5'b10000;
  localparam logic [4:0] LH  = 5'b01000;
  localparam logic [4:0] LW  = 5'b00100;
  localparam logic [4:0] LBU = 5'b00010;
  localparam logic [4:0] LHU = 5'b00001;
  localparam logic [2:0] SB  = 3'b100;
  localparam logic [2:0] SH  = 3'b010;
  localparam logic [2:0] SW  = 3'b001;
  localparam logic [5:0] GO     = 6'b000000;
  localparam logic [5:0] BUBBLE = 6'b001000;
  localparam logic [5:0] HOLD   = 6'b011000;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model: which instruction sits in MEM, and whether read data is frozen
  logic [75:0] m_bus;
  logic [4:0]  m_load;
  logic [2:0]  m_store;
  bit          m_held;
  logic [31:0] m_hold;
  logic [31:0] cur_rdata;
  logic [69:0] exp_wb;
  logic [37:0] exp_id;
  logic        exp_err;

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic sel, input logic we,
                                        input logic [4:0] wa, input logic [31:0] res);
    return {pc, 1'b1, 4'b0000, sel, we, wa, res};
  endfunction

  function automatic logic [31:0] load_value(input logic [4:0] ld, input logic [1:0] off,
                                             input logic [31:0] rd);
    int unsigned b;
    int unsigned h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (ld)
      LB:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
      LHU:     return h;
      LW:      return rd;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_out();
    logic [31:0] res;
    logic [31:0] wdata;
    logic [31:0] rd;
    int unsigned off;
    bit half_acc;
    bit word_acc;
    bit we;
    res = m_bus[31:0];
    off = res % 4;
    rd  = m_held ? m_hold : cur_rdata;
    wdata = m_bus[38] ? load_value(m_load, 2'(off), rd) : res;
    half_acc = (m_load == LH) || (m_load == LHU) || (m_store == SH);
    word_acc = (m_load == LW) || (m_store == SW);
    exp_err = ALIGN_EN && ((half_acc && (off % 2 == 1)) || (word_acc && off != 0));
    we = m_bus[37] && !exp_err;
    exp_wb = {m_bus[75:44], we, m_bus[36:32], wdata};
    exp_id = {we, m_bus[36:32], wdata};
  endtask

  // Apply one cycle of inputs; rd_next is SRAM data for the cycle after the edge
  task automatic step(input logic [75:0] bus, input logic [4:0] ld, input logic [2:0] st,
                      input logic [5:0] stl, input logic [31:0] rd_next);
    ex_to_mem_bus      = bus;
    load_sram_ex_data  = ld;
    store_sram_ex_data = st;
    stall              = stl;
    @(posedge clk);
    if (!stl[3]) begin
      m_bus = bus; m_load = ld; m_store = st; m_held = 1'b0;
    end else if (!stl[4]) begin
      m_bus = '0; m_load = '0; m_store = '0; m_held = 1'b0;
    end else if (!m_held) begin
      m_held = 1'b1; m_hold = cur_rdata;
    end
    #1;
    data_sram_rdata = rd_next;
    cur_rdata       = rd_next;
    #1;
    model_out();
  endtask

  task automatic model_reset();
    m_bus = '0; m_load = '0; m_store = '0; m_held = 1'b0; m_hold = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = GO;
    ex_to_mem_bus = mk_ex(32'h0000_0400, 1'b0, 1'b1, 5'd3, 32'h55AA_55AA);
    load_sram_ex_data = LW;
    store_sram_ex_data = '0;
    data_sram_rdata = 32'hFFFF_FFFF;
    cur_rdata = 32'hFFFF_FFFF;
    model_reset();
    #7;
    n_checks++;
    if (mem_to_wb_bus !== 70'h0) $display("FAIL reset_wb: got %h want 0", mem_to_wb_bus);
    else n_pass++;
    n_checks++;
    if (mem_to_id_bus !== 38'h0) $display("FAIL reset_id: got %h want 0", mem_to_id_bus);
    else n_pass++;
    n_checks++;
    if (addr_err !== 1'b0) $display("FAIL reset_err: got %b want 0", addr_err);
    else n_pass++;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_load_align();
    logic [4:0]  lds  [3];
    logic [31:0] want [3];
    step(mk_ex(32'h0000_1000, 1'b1, 1'b1, 5'd5, 32'h0000_0103), LB, 3'b000, GO, 32'h8011_2233);
    n_checks++;
    if (mem_to_wb_bus[31:0] !== 32'hFFFF_FF80)
      $display("FAIL lb_off3_wb: got %h want ffffff80", mem_to_wb_bus[31:0]);
    else n_pass++;
    n_checks++;
    if (mem_to_id_bus !== {1'b1, 5'd5, 32'hFFFF_FF80})
      $display("FAIL lb_off3_id: got %h want %h", mem_to_id_bus, {1'b1, 5'd5, 32'hFFFF_FF80});
    else n_pass++;
    n_checks++;
    if (mem_to_wb_bus !== exp_wb) $display("FAIL lb_off3_model: got %h want %h", mem_to_wb_bus, exp_wb);
    else n_pass++;
    lds[0] = LBU; want[0] = 32'h0000_00BC;
    lds[1] = LHU; want[1] = 32'h0000_9ABC;
    lds[2] = LH;  want[2] = 32'hFFFF_9ABC;
    for (int i = 0; i < 3; i++) begin
      step(mk_ex(32'h0000_1004 + 32'(4 * i), 1'b1, 1'b1, 5'd6, 32'h0000_2002), lds[i], 3'b000, GO,
           32'h9ABC_1234);
      n_checks++;
      if (mem_to_wb_bus[31:0] !== want[i])
        $display("FAIL off2_load%0d_wb: got %h want %h", i, mem_to_wb_bus[31:0], want[i]);
      else n_pass++;
      n_checks++;
      if (mem_to_id_bus !== exp_id)
        $display("FAIL off2_load%0d_id: got %h want %h", i, mem_to_id_bus, exp_id);
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    logic [75:0] lw_bus;
    lw_bus = mk_ex(32'h0000_2000, 1'b1, 1'b1, 5'd7, 32'h0000_2000);
    step(lw_bus, LW, 3'b000, GO, 32'hDEAD_BEEF);
    n_checks++;
    if (mem_to_wb_bus[31:0] !== 32'hDEAD_BEEF)
      $display("FAIL hold_live: got %h want deadbeef", mem_to_wb_bus[31:0]);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(mk_ex(32'h0000_2004, 1'b0, 1'b1, 5'd8, 32'h0000_0099), '0, 3'b000, HOLD, 32'h0000_0000);
      n_checks++;
      if (mem_to_wb_bus[31:0] !== 32'hDEAD_BEEF)
        $display("FAIL hold_cycle%0d: got %h want deadbeef", i, mem_to_wb_bus[31:0]);
      else n_pass++;
      n_checks++;
      if (mem_to_id_bus !== exp_id)
        $display("FAIL hold_cycle%0d_id: got %h want %h", i, mem_to_id_bus, exp_id);
      else n_pass++;
    end
    step(mk_ex(32'h0000_2008, 1'b1, 1'b1, 5'd9, 32'h0000_2100), LW, 3'b000, GO, 32'h1357_9BDF);
    n_checks++;
    if (mem_to_wb_bus !== {32'h0000_2008, 1'b1, 5'd9, 32'h1357_9BDF})
      $display("FAIL hold_release: got %h want %h", mem_to_wb_bus,
               {32'h0000_2008, 1'b1, 5'd9, 32'h1357_9BDF});
    else n_pass++;
  endtask

  task automatic test_bubble();
    step(mk_ex(32'h0000_3000, 1'b0, 1'b1, 5'd4, 32'h0000_0777), '0, 3'b000, GO, $urandom);
    step(mk_ex(32'h0000_3004, 1'b0, 1'b1, 5'd4, 32'h0000_0888), '0, 3'b000, BUBBLE, $urandom);
    n_checks++;
    if (mem_to_wb_bus !== 70'h0) $display("FAIL bubble_wb: got %h want 0", mem_to_wb_bus);
    else n_pass++;
    n_checks++;
    if (mem_to_id_bus[37] !== 1'b0) $display("FAIL bubble_we: got %b want 0", mem_to_id_bus[37]);
    else n_pass++;
    step(mk_ex(32'h0000_3008, 1'b0, 1'b1, 5'd10, 32'h0000_1234), '0, 3'b000, GO, 32'hFFFF_FFFF);
    n_checks++;
    if (mem_to_wb_bus !== {32'h0000_3008, 1'b1, 5'd10, 32'h0000_1234})
      $display("FAIL alu_pass: got %h want %h", mem_to_wb_bus,
               {32'h0000_3008, 1'b1, 5'd10, 32'h0000_1234});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    step(mk_ex(32'h0000_4000, 1'b1, 1'b1, 5'd11, 32'h0000_4000), LW, 3'b000, GO, 32'hCAFE_F00D);
    step(mk_ex(32'h0000_4004, 1'b1, 1'b1, 5'd12, 32'h0000_4004), LW, 3'b000, HOLD, 32'h0000_0000);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_to_wb_bus !== 70'h0) $display("FAIL async_rst_wb: got %h want 0", mem_to_wb_bus);
    else n_pass++;
    n_checks++;
    if (mem_to_id_bus !== 38'h0) $display("FAIL async_rst_id: got %h want 0", mem_to_id_bus);
    else n_pass++;
    model_reset();
    #2;
    rst = 1'b0;
    step(mk_ex(32'h0000_4008, 1'b1, 1'b1, 5'd13, 32'h0000_4008), LW, 3'b000, GO, 32'h2468_ACE0);
    n_checks++;
    if (mem_to_wb_bus[31:0] !== 32'h2468_ACE0)
      $display("FAIL async_rst_live: got %h want 2468ace0", mem_to_wb_bus[31:0]);
    else n_pass++;
  endtask

  task automatic test_align_check();
    step(mk_ex(32'h0000_5000, 1'b1, 1'b1, 5'd3, 32'h0000_5002), LW, 3'b000, GO, 32'h1122_3344);
    n_checks++;
    if (addr_err !== ALIGN_EN) $display("FAIL lw_off2_err: got %b want %b", addr_err, ALIGN_EN);
    else n_pass++;
    n_checks++;
    if (mem_to_wb_bus[37] !== !ALIGN_EN)
      $display("FAIL lw_off2_wb_we: got %b want %b", mem_to_wb_bus[37], !ALIGN_EN);
    else n_pass++;
    n_checks++;
    if (mem_to_id_bus[37] !== !ALIGN_EN)
      $display("FAIL lw_off2_id_we: got %b want %b", mem_to_id_bus[37], !ALIGN_EN);
    else n_pass++;
    step(mk_ex(32'h0000_5004, 1'b0, 1'b0, 5'd0, 32'h0000_5000), '0, SW, GO, 32'h0);
    n_checks++;
    if (addr_err !== 1'b0) $display("FAIL sw_off0_err: got %b want 0", addr_err);
    else n_pass++;
    step(mk_ex(32'h0000_5008, 1'b0, 1'b0, 5'd0, 32'h0000_5001), '0, SH, GO, 32'h0);
    n_checks++;
    if (addr_err !== ALIGN_EN) $display("FAIL sh_off1_err: got %b want %b", addr_err, ALIGN_EN);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [5:0]  stl;
    logic [4:0]  ld;
    logic [2:0]  st;
    int unsigned k;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      stl = {1'($urandom), (k == 3) ? 2'b11 : (k == 2) ? 2'b01 : 2'b00, 3'($urandom)};
      k = $urandom_range(0, 5);
      ld = (k == 0) ? 5'b0 : 5'(1 << (k - 1));
      k = $urandom_range(0, 3);
      st = (k == 0) ? 3'b0 : 3'(1 << (k - 1));
      step(mk_ex($urandom, 1'($urandom), 1'($urandom), 5'($urandom), $urandom), ld, st, stl,
           $urandom);
      n_checks++;
      if (mem_to_wb_bus !== exp_wb)
        $display("FAIL rand%0d_wb: got %h want %h", i, mem_to_wb_bus, exp_wb);
      else n_pass++;
      n_checks++;
      if (mem_to_id_bus !== exp_id)
        $display("FAIL rand%0d_id: got %h want %h", i, mem_to_id_bus, exp_id);
      else n_pass++;
      n_checks++;
      if (addr_err !== exp_err)
        $display("FAIL rand%0d_err: got %b want %b", i, addr_err, exp_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_load_align();
    test_hold();
    test_bubble();
    test_async_reset();
    test_align_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
